fetch_pcgen: RTL and testbench
==============================

FETCH_PCGEN -- requirements
Module: fetch_pcgen

Interface
REQ-001 SHALL have parameters: FETCH_BYTES, default 8, fetch-line size in bytes (legal 4/8/16); RAS_DEPTH, default 4, return-stack entries (power of 2, 2..16).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port cpurst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port boot_addr  in  32  reset PC.
REQ-005 SHALL have ports redirect_valid/redirect_pc  in  1/32  mispredict correction.
REQ-006 SHALL have ports trap_valid/trap_pc  in  1/32  trap vector, precomputed.
REQ-007 SHALL have ports mret_valid/mret_pc  in  1/32  return-from-trap target.
REQ-008 SHALL have port stall  in  1  OR of downstream stalls; holds PC.
REQ-009 SHALL have ports pred_valid/pred_target  in  1/32  jal, jalr or predicted-taken bxx from mini-decode.
REQ-010 SHALL have ports pred_is_call/pred_is_ret/call_ret_addr  in  1/1/32  RAS push/pop hints and push value.
REQ-011 SHALL have port instr_len16  in  1  current instruction is 16-bit.
REQ-012 SHALL have ports pc  out  32  current fetch PC; isram_adr  out  32-log2(FETCH_BYTES)  line address; isram_cs  out  1  line read strobe.
REQ-013 SHALL have ports fet_stall  out  1  flush decode, PC held; jb_ff  out  1  registered non-sequential flag; ras_empty  out  1.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, SPLIT; BOOT->RUN after one cycle; RUN->SPLIT per REQ-019; SPLIT->RUN after one cycle.
REQ-015 nxtpc priority SHALL be redirect_valid > trap_valid > mret_valid > (stall|fet_stall: hold pc) > pred_valid (RAS top if pred_is_ret and not empty, else pred_target) > pc+(instr_len16?2:4).
REQ-016 pc SHALL load nxtpc every cycle. All targets SHALL have bit0 forced to 0. Additions SHALL wrap modulo 2^32.
REQ-017 In BOOT: nxtpc=pc, isram_adr=pc line, isram_cs=1, fet_stall=1.
REQ-018 Non-sequential (jc) SHALL mean any of redirect, trap, mret, pred_valid taken; jb_ff SHALL register jc one cycle later.
REQ-019 Split: nxtpc offset == FETCH_BYTES-2. With jc=0, isram_adr SHALL be nxtpc line+1 and no extra cycle is used. With jc=1, isram_adr SHALL be nxtpc line and the FSM SHALL enter SPLIT.
REQ-020 In SPLIT: isram_adr=pc line+1, isram_cs=1, fet_stall=1, pc held. Exception: redirect/trap/mret in SPLIT SHALL take effect per REQ-015 and abort the second beat.
REQ-021 In all other cases isram_adr SHALL equal nxtpc line.
REQ-022 isram_cs SHALL be 1 in BOOT/SPLIT, or when isram_adr differs from the last issued line address, or on jc; otherwise 0.
REQ-023 RAS push SHALL occur on accepted pred_is_call, pop on accepted pred_is_ret. Accepted means pred_valid, no higher-priority source, no stall, not SPLIT.
REQ-024 Call and ret in the same cycle SHALL use the old top as target, then overwrite the top with call_ret_addr; the count is unchanged.
REQ-025 Push when full SHALL overwrite the oldest entry circularly, count saturating at RAS_DEPTH. Pop when empty SHALL use pred_target and the count SHALL stay 0.
REQ-026 redirect/trap/mret SHALL NOT modify RAS contents.

Reset
REQ-027 While cpurst_n=0, asynchronously: pc=boot_addr, state=BOOT, isram_cs=0, fet_stall=0, jb_ff=0, RAS count=0, ras_empty=1, last-line register=all ones.
REQ-028 Reset asserted mid-SPLIT or mid-stall SHALL discard all in-flight state; the first cycle after release SHALL be BOOT.

Configuration
REQ-029 Macro FETCH_PCGEN_RAS_EN defined: RAS per REQ-023..026 SHALL be present.
REQ-030 Macro absent: no RAS storage SHALL exist; pred_target SHALL always be used; pred_is_call/pred_is_ret/call_ret_addr SHALL be ignored; ras_empty SHALL be tied 1.

Verification (FETCH_BYTES=8, RAS_DEPTH=4, boot_addr=0x8000_0000)
REQ-031 Release reset -> BOOT cycle: isram_adr=0x1000_0000, isram_cs=1, pc=0x8000_0000. Next cycle with 32-bit instructions: pc=0x8000_0004.
REQ-032 Sequential pc=0x8000_0002, 32-bit, no jump -> nxtpc 0x8000_0006, isram_adr=0x1000_0001, no SPLIT cycle.
REQ-033 pred_valid, pred_target=0x8000_0106 -> SPLIT entered: line 0x1000_0020 then 0x1000_0021, fet_stall=1 for one cycle, jb_ff=1.
REQ-034 Five calls (ret addrs A..E) then five rets -> targets E,D,C,B. Fifth ret sees empty RAS, uses pred_target, ras_empty=1. Rebuild without macro -> all five use pred_target.
REQ-035 redirect_valid, trap_valid and stall all asserted in one cycle -> pc=redirect_pc. Trap alone during stall -> pc=trap_pc.
REQ-036 cpurst_n pulsed low during SPLIT -> pc=0x8000_0000 immediately (asynchronous), RAS count=0, BOOT follows release.

Source files
------------

// File: rtl/fetch_pcgen.sv
// fetch_pcgen: next-PC select, I-SRAM line addressing and split-line fetch.
// Build option FETCH_PCGEN_RAS_EN adds a circular return-address stack.
//
// Ports:
//   clk, cpurst_n               clock, async active-low reset
//   boot_addr                   PC loaded while in reset
//   redirect_valid/redirect_pc  mispredict correction (highest priority)
//   trap_valid/trap_pc          trap vector
//   mret_valid/mret_pc          return-from-trap target
//   stall                       downstream stall, holds PC
//   pred_valid/pred_target      mini-decode predicted jump
//   pred_is_call/pred_is_ret    RAS push/pop hints
//   call_ret_addr               RAS push value
//   instr_len16                 current instruction is 16-bit
//   pc                          current fetch PC
//   isram_adr/isram_cs          line address and read strobe
//   fet_stall                   flush decode, PC held
//   jb_ff                       registered non-sequential flag
//   ras_empty                   return stack holds no entries
module fetch_pcgen #(
  parameter int FETCH_BYTES = 8,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                cpurst_n,
  input  logic [31:0]                         boot_addr,
  input  logic                                redirect_valid,
  input  logic [31:0]                         redirect_pc,
  input  logic                                trap_valid,
  input  logic [31:0]                         trap_pc,
  input  logic                                mret_valid,
  input  logic [31:0]                         mret_pc,
  input  logic                                stall,
  input  logic                                pred_valid,
  input  logic [31:0]                         pred_target,
  input  logic                                pred_is_call,
  input  logic                                pred_is_ret,
  input  logic [31:0]                         call_ret_addr,
  input  logic                                instr_len16,
  output logic [31:0]                         pc,
  output logic [31-$clog2(FETCH_BYTES):0]     isram_adr,
  output logic                                isram_cs,
  output logic                                fet_stall,
  output logic                                jb_ff,
  output logic                                ras_empty
);

  localparam int OFFW = $clog2(FETCH_BYTES);
  localparam int LW   = 32 - OFFW;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_SPLIT
  } state_t;

  state_t          r_state;
  state_t          w_st_n;
  logic [31:0]     r_pc;
  logic [LW-1:0]   r_last;
  logic            r_jb;

  logic [31:0]     w_nxt;
  logic [LW-1:0]   w_adr;
  logic            w_jc;
  logic            w_acc;
  logic            w_cs_raw;
  logic            w_hi;
  logic            w_fs;
  logic [31:0]     w_pred_tgt;
  logic            w_ras_empty;

  assign w_hi = redirect_valid | trap_valid | mret_valid;
  assign w_fs = (r_state != S_RUN);

`ifdef FETCH_PCGEN_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [31:0]   r_ras [RAS_DEPTH];
  logic [PW-1:0] r_sp;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_top;
  logic          w_push;
  logic          w_pop;

  // r_sp points at the next free slot; the top is one below it.
  assign w_top       = r_sp - PW'(1);
  assign w_ras_empty = (r_cnt == '0);
  assign w_pred_tgt  = (pred_is_ret && !w_ras_empty) ?
                       r_ras[w_top] : pred_target;
  assign w_push      = w_acc & pred_is_call;
  assign w_pop       = w_acc & pred_is_ret & ~w_ras_empty;

  // Call+ret together replaces the top in place: depth unchanged.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (w_push && !w_pop) begin
      r_sp <= r_sp + PW'(1);
      if (r_cnt != CW'(RAS_DEPTH))
        r_cnt <= r_cnt + CW'(1);
    end else if (w_pop && !w_push) begin
      r_sp  <= w_top;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      if (w_pop)
        r_ras[w_top] <= call_ret_addr;
      else
        r_ras[r_sp] <= call_ret_addr;
    end
  end
`else
  logic w_unused_ras;

  assign w_ras_empty  = 1'b1;
  assign w_pred_tgt   = pred_target;
  assign w_unused_ras = ^{pred_is_call, pred_is_ret,
                          call_ret_addr};
`endif

  always_comb begin
    w_nxt    = r_pc;
    w_jc     = 1'b0;
    w_acc    = 1'b0;
    w_adr    = r_pc[31:OFFW];
    w_cs_raw = 1'b0;
    w_st_n   = S_RUN;
    if (r_state == S_BOOT) begin
      w_cs_raw = 1'b1;
    end else begin
      if (redirect_valid) begin
        w_nxt = redirect_pc;
        w_jc  = 1'b1;
      end else if (trap_valid) begin
        w_nxt = trap_pc;
        w_jc  = 1'b1;
      end else if (mret_valid) begin
        w_nxt = mret_pc;
        w_jc  = 1'b1;
      end else if (stall || w_fs) begin
        w_nxt = r_pc;
      end else if (pred_valid) begin
        w_nxt = w_pred_tgt;
        w_jc  = 1'b1;
        w_acc = 1'b1;
      end else begin
        w_nxt = r_pc + (instr_len16 ? 32'd2 : 32'd4);
      end
      w_nxt[0] = 1'b0;
      // A 32-bit op at the last halfword straddles two lines.
      // Sequential flow already holds the low half, so fetch
      // ahead; after a jump both lines are needed: two beats.
      if (r_state == S_SPLIT && !w_hi) begin
        w_adr    = r_pc[31:OFFW] + LW'(1);
        w_cs_raw = 1'b1;
      end else if (w_nxt[OFFW-1:0] == OFFW'(FETCH_BYTES - 2)) begin
        if (w_jc) begin
          w_adr  = w_nxt[31:OFFW];
          w_st_n = S_SPLIT;
        end else begin
          w_adr  = w_nxt[31:OFFW] + LW'(1);
        end
      end else begin
        w_adr = w_nxt[31:OFFW];
      end
    end
    if (w_adr != r_last || w_jc)
      w_cs_raw = 1'b1;
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_st_n;
    end
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      r_pc   <= {boot_addr[31:1], 1'b0};
      r_jb   <= 1'b0;
      r_last <= '1;
    end else begin
      r_pc <= w_nxt;
      r_jb <= w_jc;
      if (w_cs_raw)
        r_last <= w_adr;
    end
  end

  // Strobes are forced low while reset is held even though the
  // state register already sits in BOOT.
  assign pc        = r_pc;
  assign isram_adr = w_adr;
  assign isram_cs  = cpurst_n & w_cs_raw;
  assign fet_stall = cpurst_n & w_fs;
  assign jb_ff     = r_jb;
  assign ras_empty = w_ras_empty;

endmodule

// File: tb/tb_fetch_pcgen.sv
// tb_fetch_pcgen: vector table plus directed sequences for fetch_pcgen.
// Expected next-PC/jb values flow through a scoreboard queue.
module tb_fetch_pcgen;

  logic        clk = 1'b0;
  logic        cpurst_n;
  logic [31:0] boot_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        mret_valid;
  logic [31:0] mret_pc;
  logic        stall;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic        pred_is_call;
  logic        pred_is_ret;
  logic [31:0] call_ret_addr;
  logic        instr_len16;
  logic [31:0] pc;
  logic [28:0] isram_adr;
  logic        isram_cs;
  logic        fet_stall;
  logic        jb_ff;
  logic        ras_empty;

  fetch_pcgen #(
    .FETCH_BYTES(8),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .cpurst_n(cpurst_n),
    .boot_addr(boot_addr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .trap_valid(trap_valid),
    .trap_pc(trap_pc),
    .mret_valid(mret_valid),
    .mret_pc(mret_pc),
    .stall(stall),
    .pred_valid(pred_valid),
    .pred_target(pred_target),
    .pred_is_call(pred_is_call),
    .pred_is_ret(pred_is_ret),
    .call_ret_addr(call_ret_addr),
    .instr_len16(instr_len16),
    .pc(pc),
    .isram_adr(isram_adr),
    .isram_cs(isram_cs),
    .fet_stall(fet_stall),
    .jb_ff(jb_ff),
    .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        tv;
    logic [31:0] tpc;
    logic        mv;
    logic [31:0] mpc;
    logic        st;
    logic        pv;
    logic [31:0] pt;
    logic        call;
    logic        ret;
    logic [31:0] cra;
    logic        l16;
    logic [31:0] eadr;
    logic        ecs;
    logic        efs;
    logic [31:0] epc;
    logic        ejb;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        jb;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[14];

`ifdef FETCH_PCGEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rv, input logic [31:0] rpc,
    input logic tv, input logic [31:0] tpc,
    input logic mv, input logic [31:0] mpc,
    input logic st, input logic pv, input logic [31:0] pt,
    input logic l16, input logic [31:0] eadr, input logic ecs,
    input logic efs, input logic [31:0] epc, input logic ejb);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.tv = tv; v.tpc = tpc;
    v.mv = mv; v.mpc = mpc; v.st = st; v.pv = pv; v.pt = pt;
    v.call = 1'b0; v.ret = 1'b0; v.cra = '0;
    v.l16 = l16; v.eadr = eadr; v.ecs = ecs; v.efs = efs;
    v.epc = epc; v.ejb = ejb;
    return v;
  endfunction

  function automatic vec_t idle_v(input logic [31:0] eadr,
    input logic ecs, input logic efs, input logic [31:0] epc,
    input logic ejb);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eadr, ecs, efs, epc, ejb);
  endfunction

  task automatic idle();
    redirect_valid = 0; redirect_pc = '0;
    trap_valid = 0; trap_pc = '0;
    mret_valid = 0; mret_pc = '0;
    stall = 0; pred_valid = 0; pred_target = '0;
    pred_is_call = 0; pred_is_ret = 0; call_ret_addr = '0;
    instr_len16 = 0;
  endtask

  task automatic retire(input string nm);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s.sb: got empty queue want entry", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, ".pc"}, pc, e.pc);
      chk({nm, ".jb"}, 32'(jb_ff), 32'(e.jb));
    end
  endtask

  // Called at posedge+1: drive, check comb outputs, retire after edge.
  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    redirect_valid = v.rv; redirect_pc = v.rpc;
    trap_valid = v.tv; trap_pc = v.tpc;
    mret_valid = v.mv; mret_pc = v.mpc;
    stall = v.st; pred_valid = v.pv; pred_target = v.pt;
    pred_is_call = v.call; pred_is_ret = v.ret;
    call_ret_addr = v.cra; instr_len16 = v.l16;
    #1;
    chk({nm, ".adr"}, 32'(isram_adr), v.eadr);
    chk({nm, ".cs"}, 32'(isram_cs), 32'(v.ecs));
    chk({nm, ".fs"}, 32'(fet_stall), 32'(v.efs));
    e.pc = v.epc;
    e.jb = v.ejb;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    retire(nm);
    idle();
  endtask

  initial begin
    vec_t v;
    logic [31:0] tg;
    cpurst_n = 1'b0;
    boot_addr = 32'h8000_0000;
    idle();

    tbl[0]  = mk(1, 32'h8000_0002, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h1000_0000, 1, 0, 32'h8000_0002, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h1000_0001, 1, 0, 32'h8000_0006, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,
                 32'h1000_0001, 0, 0, 32'h8000_0006, 0);
    tbl[3]  = mk(1, 32'h8000_0041, 1, 32'h9000_0000, 0, 0, 1, 0, 0, 0,
                 32'h1000_0008, 1, 0, 32'h8000_0040, 1);
    tbl[4]  = mk(0, 0, 1, 32'h9000_0010, 0, 0, 1, 0, 0, 0,
                 32'h1200_0002, 1, 0, 32'h9000_0010, 1);
    tbl[5]  = mk(0, 0, 0, 0, 1, 32'h8000_0200, 1, 1, 32'h8000_0500, 0,
                 32'h1000_0040, 1, 0, 32'h8000_0200, 1);
    tbl[6]  = mk(0, 0, 1, 32'h9000_0020, 1, 32'h8000_0400, 0, 0, 0, 0,
                 32'h1200_0004, 1, 0, 32'h9000_0020, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0300, 0,
                 32'h1200_0004, 0, 0, 32'h9000_0020, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0301, 0,
                 32'h1000_0060, 1, 0, 32'h8000_0300, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                 32'h1000_0060, 0, 0, 32'h8000_0302, 0);
    tbl[10] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h1FFF_FFFF, 1, 0, 32'hFFFF_FFFC, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h0000_0000, 1, 0, 32'h0000_0000, 0);
    tbl[12] = mk(1, 32'hFFFF_FFFA, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h1FFF_FFFF, 1, 0, 32'hFFFF_FFFA, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h0000_0000, 1, 0, 32'hFFFF_FFFE, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc", pc, 32'h8000_0000);
    chk("rst.cs", 32'(isram_cs), 0);
    chk("rst.fs", 32'(fet_stall), 0);
    chk("rst.jb", 32'(jb_ff), 0);
    chk("rst.ras_empty", 32'(ras_empty), 1);

    // BOOT cycle then sequential start
    cpurst_n = 1'b1;
    #1;
    chk("boot.adr", 32'(isram_adr), 32'h1000_0000);
    chk("boot.cs", 32'(isram_cs), 1);
    chk("boot.fs", 32'(fet_stall), 1);
    chk("boot.pc", pc, 32'h8000_0000);
    @(posedge clk);
    #1;
    chk("run0.pc", pc, 32'h8000_0000);
    chk("run0.fs", 32'(fet_stall), 0);
    chk("run0.cs", 32'(isram_cs), 0);
    @(posedge clk);
    #1;
    chk("run1.pc", pc, 32'h8000_0004);

    for (int i = 0; i < 14; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Jump to last halfword of a line: two-beat fetch
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0106, 0,
             32'h1000_0020, 1, 0, 32'h8000_0106, 1), "split.jmp");
    apply(idle_v(32'h1000_0021, 1, 1, 32'h8000_0106, 0), "split.beat2");
    apply(idle_v(32'h1000_0021, 0, 0, 32'h8000_010A, 0), "split.after");

    // Trap during SPLIT aborts the second beat
    apply(mk(1, 32'h8000_0206, 0, 0, 0, 0, 0, 0, 0, 0,
             32'h1000_0040, 1, 0, 32'h8000_0206, 1), "abort.jmp");
    apply(mk(0, 0, 1, 32'h9000_0000, 0, 0, 0, 0, 0, 0,
             32'h1200_0000, 1, 1, 32'h9000_0000, 1), "abort.trap");
    apply(idle_v(32'h1200_0000, 0, 0, 32'h9000_0004, 0), "abort.after");

    // Five calls, five returns
    for (int i = 0; i < 5; i++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_1000 + 32'(i) * 32'h40, 0,
             (32'h8000_1000 + 32'(i) * 32'h40) >> 3, 1, 0,
             32'h8000_1000 + 32'(i) * 32'h40, 1);
      v.call = 1'b1;
      v.cra  = 32'h8001_0000 + 32'(i) * 32'h100;
      apply(v, $sformatf("call%0d", i));
    end
    chk("calls.ras_empty", 32'(ras_empty), RAS_ON ? 0 : 1);
    for (int i = 0; i < 5; i++) begin
      if (RAS_ON && i < 4)
        tg = 32'h8001_0000 + 32'(4 - i) * 32'h100;
      else
        tg = 32'h8000_2000 + 32'(i) * 32'h40;
      v = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_2000 + 32'(i) * 32'h40, 0,
             tg >> 3, 1, 0, tg, 1);
      v.ret = 1'b1;
      apply(v, $sformatf("ret%0d", i));
      if (i == 0)
        chk("ret0.ras_empty", 32'(ras_empty), RAS_ON ? 0 : 1);
    end
    chk("rets.ras_empty", 32'(ras_empty), 1);

    // Call and return together swap the top entry
    v = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_3000, 0,
           32'h1000_0600, 1, 0, 32'h8000_3000, 1);
    v.call = 1'b1;
    v.cra  = 32'h8002_0000;
    apply(v, "cr.push");
    tg = RAS_ON ? 32'h8002_0000 : 32'h8000_3100;
    v = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_3100, 0,
           tg >> 3, 1, 0, tg, 1);
    v.call = 1'b1;
    v.ret  = 1'b1;
    v.cra  = 32'h8003_0000;
    apply(v, "cr.both");
    tg = RAS_ON ? 32'h8003_0000 : 32'h8000_3200;
    v = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_3200, 0,
           tg >> 3, 1, 0, tg, 1);
    v.ret = 1'b1;
    apply(v, "cr.ret");
    chk("cr.ras_empty", 32'(ras_empty), 1);

    // Asynchronous reset in the middle of SPLIT
    v = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_4000, 0,
           32'h1000_0800, 1, 0, 32'h8000_4000, 1);
    v.call = 1'b1;
    v.cra  = 32'h8005_0000;
    apply(v, "ar.push");
    apply(mk(1, 32'h8000_0206, 0, 0, 0, 0, 0, 0, 0, 0,
             32'h1000_0040, 1, 0, 32'h8000_0206, 1), "ar.jmp");
    chk("ar.in_split", 32'(fet_stall), 1);
    cpurst_n = 1'b0;
    #1;
    chk("ar.pc", pc, 32'h8000_0000);
    chk("ar.fs", 32'(fet_stall), 0);
    chk("ar.cs", 32'(isram_cs), 0);
    chk("ar.jb", 32'(jb_ff), 0);
    chk("ar.ras_empty", 32'(ras_empty), 1);
    repeat (2) @(posedge clk);
    #1;
    cpurst_n = 1'b1;
    #1;
    chk("ar.boot_fs", 32'(fet_stall), 1);
    chk("ar.boot_adr", 32'(isram_adr), 32'h1000_0000);
    chk("ar.boot_cs", 32'(isram_cs), 1);
    @(posedge clk);
    #1;
    chk("ar.run_pc", pc, 32'h8000_0000);
    chk("ar.run_fs", 32'(fet_stall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
